// File: rtl/bram_sched_pkg.sv
// Shared types for the user-BRAM scheduler: FSM states, read-tag owner
// encoding and the tag carried alongside each in-flight read.
package bram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CACHE  = 2'd1,
    DMA_RD = 2'd2,
    DMA_WR = 2'd3
  } state_t;

  localparam logic OWN_CACHE = 1'b0;
  localparam logic OWN_DMA   = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register that carries read tags in step with the BRAM
// read latency; a synchronous clear drops everything in flight.
module rd_tag_pipe
  import bram_sched_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic    wb_clk_i,
  input  logic    i_clr,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [RD_LAT];

  always_ff @(posedge wb_clk_i) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/bram_sched.sv
// Round-robin arbiter and burst sequencer sharing the single-port user BRAM
// between the I-cache refill path and the DMA controller.
module bram_sched
  import bram_sched_pkg::*;
#(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_rvalid,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              cache_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [3:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wnext,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do
);

  localparam int unsigned LINE_LOG2 = $clog2(LINE_WORDS);
  localparam int unsigned BEAT_W    = (LINE_LOG2 > 4) ? LINE_LOG2 : 4;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] LINE_LAST = BEAT_W'(LINE_WORDS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_last_grant;
  logic                r_pend_cache;
  logic                r_pend_dma;
  logic                r_wr_done;

  rd_tag_t w_tag_in;
  rd_tag_t w_tag_out;
  logic    w_cache_ok;
  logic    w_dma_ok;
  logic    w_pick_cache;
  logic    w_last_beat;
  logic    w_issue_rd;
  logic    w_cache_done;
  logic    w_dma_done;

  // A requester keeps req high until its done pulse, which for reads lands
  // after the idle bubble; masking it while pending avoids a spurious re-grant.
  assign w_cache_ok   = cache_req & ~r_pend_cache;
  assign w_dma_ok     = dma_req & ~r_pend_dma;
  assign w_pick_cache = w_cache_ok & (~w_dma_ok | (r_last_grant == OWN_DMA));
  assign w_last_beat  = (r_beat == '0);
  assign w_issue_rd   = (r_state == CACHE) | (r_state == DMA_RD);

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue_rd;
    w_tag_in.owner = (r_state == CACHE) ? OWN_CACHE : OWN_DMA;
    w_tag_in.last  = w_issue_rd & w_last_beat;
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .wb_clk_i (wb_clk_i),
    .i_clr    (wb_rst_i),
    .i_tag    (w_tag_in),
    .o_tag    (w_tag_out)
  );

  assign w_cache_done = w_tag_out.valid & (w_tag_out.owner == OWN_CACHE) & w_tag_out.last;
  assign w_dma_done   = (w_tag_out.valid & (w_tag_out.owner == OWN_DMA) & w_tag_out.last)
                      | r_wr_done;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_beat       <= '0;
      r_last_grant <= OWN_DMA;
      r_pend_cache <= 1'b0;
      r_pend_dma   <= 1'b0;
      r_wr_done    <= 1'b0;
    end else begin
      r_wr_done <= (r_state == DMA_WR) & w_last_beat;
      if (w_cache_done) r_pend_cache <= 1'b0;
      if (w_dma_done)   r_pend_dma   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_cache) begin
            r_state      <= CACHE;
            r_addr       <= cache_addr & ~LINE_MASK;
            r_beat       <= LINE_LAST;
            r_last_grant <= OWN_CACHE;
            r_pend_cache <= 1'b1;
          end else if (w_dma_ok) begin
            r_state      <= dma_we ? DMA_WR : DMA_RD;
            r_addr       <= dma_addr;
            r_beat       <= BEAT_W'(dma_len);
            r_last_grant <= OWN_DMA;
            r_pend_dma   <= 1'b1;
          end
        end
        default: begin
          r_addr <= r_addr + 1'b1;
          r_beat <= r_beat - 1'b1;
          if (w_last_beat) r_state <= IDLE;
        end
      endcase
    end
  end

  assign bram_en   = (r_state != IDLE);
  assign bram_we   = (r_state == DMA_WR);
  assign bram_addr = bram_en ? r_addr : '0;
  assign bram_di   = bram_we ? dma_wdata : '0;
  assign dma_wnext = bram_we;

  assign cache_rvalid = w_tag_out.valid & (w_tag_out.owner == OWN_CACHE);
  assign dma_rvalid   = w_tag_out.valid & (w_tag_out.owner == OWN_DMA);
  assign cache_rdata  = cache_rvalid ? bram_do : '0;
  assign dma_rdata    = dma_rvalid ? bram_do : '0;
  assign cache_done   = w_cache_done;
  assign dma_done     = w_dma_done;

endmodule

// File: tb/tb_bram_sched.sv
// Directed bench for bram_sched: cycle-exact expected output vectors for each
// scenario, with a two-cycle-latency BRAM whose read word is a function of address.
module tb_bram_sched;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cache_req = 1'b0;
  logic [12:0] cache_addr = '0;
  logic        cache_rvalid;
  logic [31:0] cache_rdata;
  logic        cache_done;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [12:0] dma_addr = '0;
  logic [3:0]  dma_len = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_wnext;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic        bram_en;
  logic        bram_we;
  logic [12:0] bram_addr;
  logic [31:0] bram_di;
  logic [31:0] bram_do;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  bram_sched #(.ADDR_W(13), .DATA_W(32), .LINE_WORDS(8), .RD_LAT(2)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .cache_req    (cache_req),
    .cache_addr   (cache_addr),
    .cache_rvalid (cache_rvalid),
    .cache_rdata  (cache_rdata),
    .cache_done   (cache_done),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_len      (dma_len),
    .dma_wdata    (dma_wdata),
    .dma_wnext    (dma_wnext),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .dma_done     (dma_done),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_di      (bram_di),
    .bram_do      (bram_do)
  );

  function automatic logic [31:0] mem_f(input logic [12:0] a);
    return 32'hB000_0000 | {19'd0, a};
  endfunction

  // BRAM stand-in: read word appears two cycles after the read command
  logic [31:0] r_rd0 = 32'h0BAD_0BAD;
  logic [31:0] r_rd1 = 32'h0BAD_0BAD;
  always @(posedge wb_clk_i) begin
    r_rd0 <= (bram_en && !bram_we) ? mem_f(bram_addr) : 32'h0BAD_0BAD;
    r_rd1 <= r_rd0;
  end
  assign bram_do = r_rd1;

  logic [115:0] w_obs;
  assign w_obs = {bram_en, bram_we, bram_addr, bram_di, dma_wnext,
                  cache_rvalid, cache_rdata, cache_done,
                  dma_rvalid, dma_rdata, dma_done};

  function automatic logic [115:0] ev(input logic en, input logic we,
                                      input logic [12:0] addr, input logic [31:0] di,
                                      input logic crv, input logic [12:0] cra, input logic cd,
                                      input logic drv, input logic [12:0] dra, input logic dd);
    logic [31:0] cr;
    logic [31:0] dr;
    cr = crv ? mem_f(cra) : 32'h0;
    dr = drv ? mem_f(dra) : 32'h0;
    return {en, we, en ? addr : 13'h0, we ? di : 32'h0, we, crv, cr, cd, drv, dr, dd};
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [115:0] obs, input logic [115:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, ncache, ndma, prev_owner, alt_err, cyc, diff;
    logic prev_en;

    repeat (3) tick();
    chk("reset_outputs", w_obs, '0);
    wb_rst_i = 1'b0;
    tick();

    // cache refill, unaligned base 0x0013 -> line 0x0010
    cache_addr = 13'h0013;
    cache_req  = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("cache_k%0d", k), w_obs,
          ev(k <= 8, 1'b0, 13'h0010 + 13'(k-1), 32'h0,
             k >= 3 && k <= 10, 13'h0010 + 13'(k-3), k == 10,
             1'b0, 13'h0, 1'b0));
      if (k == 10) cache_req = 1'b0;
    end

    // DMA write wrapping past the top of the address space
    dma_addr  = 13'h1FFE;
    dma_len   = 4'd3;
    dma_we    = 1'b1;
    dma_wdata = 32'h1000_0000;
    dma_req   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("dmawr_k%0d", k), w_obs,
          ev(k <= 4, k <= 4, 13'h1FFE + 13'(k-1), 32'h1000_0000 + 32'(k-1),
             1'b0, 13'h0, 1'b0, 1'b0, 13'h0, k == 5));
      if (k <= 4) dma_wdata = 32'h1000_0000 + 32'(k);
      if (k == 5) dma_req = 1'b0;
    end

    // simultaneous pair straight after reset: cache first, DMA after bubble
    wb_rst_i = 1'b1;
    tick();
    tick();
    chk("reset2_outputs", w_obs, '0);
    wb_rst_i   = 1'b0;
    cache_addr = 13'h0020;
    dma_addr   = 13'h0100;
    dma_len    = 4'd1;
    dma_we     = 1'b1;
    dma_wdata  = 32'h2000_0000;
    cache_req  = 1'b1;
    dma_req    = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("pair1_k%0d", k), w_obs,
          ev(k <= 8 || k == 10 || k == 11, k == 10 || k == 11,
             (k <= 8) ? 13'h0020 + 13'(k-1) : 13'h0100 + 13'(k-10),
             32'h2000_0000 + 32'(k-10),
             k >= 3 && k <= 10, 13'h0020 + 13'(k-3), k == 10,
             1'b0, 13'h0, k == 12));
      if (k == 10) begin
        cache_req = 1'b0;
        dma_wdata = 32'h2000_0001;
      end
      if (k == 12) dma_req = 1'b0;
    end

    // cache-only refill so that cache holds last_grant
    cache_addr = 13'h0047;
    cache_req  = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("cache2_k%0d", k), w_obs,
          ev(k <= 8, 1'b0, 13'h0040 + 13'(k-1), 32'h0,
             k >= 3 && k <= 10, 13'h0040 + 13'(k-3), k == 10,
             1'b0, 13'h0, 1'b0));
      if (k == 10) cache_req = 1'b0;
    end

    // tie after a cache grant: single-word DMA read wins, refill follows
    dma_addr   = 13'h0300;
    dma_len    = 4'd0;
    dma_we     = 1'b0;
    cache_addr = 13'h0080;
    dma_req    = 1'b1;
    cache_req  = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("pair2_k%0d", k), w_obs,
          ev(k == 1 || (k >= 3 && k <= 10), 1'b0,
             (k == 1) ? 13'h0300 : 13'h0080 + 13'(k-3), 32'h0,
             k >= 5 && k <= 12, 13'h0080 + 13'(k-5), k == 12,
             k == 3, 13'h0300, k == 3));
      if (k == 3) dma_req = 1'b0;
      if (k == 12) cache_req = 1'b0;
    end

    // reset during the third beat of a DMA read drops in-flight responses
    dma_addr = 13'h0400;
    dma_len  = 4'd7;
    dma_we   = 1'b0;
    dma_req  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("rstmid_k%0d", k), w_obs,
          (k <= 3) ? ev(1'b1, 1'b0, 13'h0400 + 13'(k-1), 32'h0,
                        1'b0, 13'h0, 1'b0, k == 3, 13'h0400, 1'b0)
                   : 116'h0);
      if (k == 3) begin
        wb_rst_i = 1'b1;
        dma_req  = 1'b0;
      end
      if (k == 4) wb_rst_i = 1'b0;
    end

    // normal DMA read after reset
    dma_addr = 13'h0500;
    dma_len  = 4'd2;
    dma_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("dmard_k%0d", k), w_obs,
          ev(k <= 3, 1'b0, 13'h0500 + 13'(k-1), 32'h0,
             1'b0, 13'h0, 1'b0, k >= 3 && k <= 5, 13'h0500 + 13'(k-3), k == 5));
      if (k == 5) dma_req = 1'b0;
    end

    // sustained contention: 100 transactions must alternate owners
    cache_addr = 13'h0000;
    dma_addr   = 13'h0700;
    dma_len    = 4'd0;
    dma_we     = 1'b1;
    dma_wdata  = 32'h3000_0000;
    cache_req  = 1'b1;
    dma_req    = 1'b1;
    starts = 0; ncache = 0; ndma = 0; prev_owner = -1; alt_err = 0; cyc = 0;
    prev_en = 1'b0;
    while (starts < 100 && cyc < 3000) begin
      tick();
      cyc++;
      if (bram_en && !prev_en) begin
        starts++;
        if (bram_we) ndma++;
        else ncache++;
        if (int'(bram_we) == prev_owner) alt_err++;
        prev_owner = int'(bram_we);
      end
      prev_en   = bram_en;
      cache_req = !cache_done;
      dma_req   = !dma_done;
    end
    cache_req = 1'b0;
    dma_req   = 1'b0;
    chk("rr_budget", 116'(starts), 116'(100));
    chk("rr_alternate", 116'(alt_err), 116'(0));
    chk("rr_cache_cnt", 116'(ncache), 116'(50));
    diff = (ncache > ndma) ? ncache - ndma : ndma - ncache;
    chk("rr_balance", 116'(diff <= 1), 116'(1));
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
